// File: rtl/singleport_ram.sv
// singleport_ram: synchronous single-port RAM with one shared address bus,
// one write enable and registered read data.
// The default geometry is 64 words x 8 bits. All storage is cleared by an
// asynchronous active-low reset, so every read returns a defined value.
//
// Optional build macro: SINGLEPORT_RAM_WRITE_THROUGH_EN
//   undefined (default) : no-change mode, q holds its value on write cycles
//   defined             : write-first mode, q <= data on in-range write cycles
module singleport_ram #(
  parameter int unsigned addr_width = 6,
  parameter int unsigned data_width = 8,
  parameter int unsigned depth      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [data_width-1:0] data,
  input  logic [addr_width-1:0] addr,
  input  logic                  WE,
  output logic [data_width-1:0] q
);

  // Depth expressed at addr_width+1 bits so that depth == 2**addr_width
  // still fits and the range compare stays unsigned and width-matched.
  localparam logic [addr_width:0] DEPTH_L = depth[addr_width:0];

  logic [data_width-1:0] r_mem [depth];
  logic [data_width-1:0] r_q;
  logic                  w_in_range;
  logic [data_width-1:0] w_rd_data;

  // Address decode and read-data select for the current cycle.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_in_range = 1'b0;
    w_rd_data  = '0;
    if ({1'b0, addr} < DEPTH_L) begin
      w_in_range = 1'b1;
      w_rd_data  = r_mem[addr];
    end
  end

  // Storage array: cleared on reset, written on in-range write edges only.
  // NOTE: the array sits inside the async-reset process because storage
  // must read as zero after reset; this maps to flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(depth); i++) begin
        r_mem[i] <= '0;
      end
    end else if (WE && w_in_range) begin
      // NOTE: non-blocking assignment so every register updates from
      // pre-edge values, independent of process evaluation order.
      r_mem[addr] <= data;
    end
  end

  // Registered read port: loads on read edges (zero when out of range),
  // and in write-first builds also loads the write data on write edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (!WE) begin
      r_q <= w_rd_data;
`ifdef SINGLEPORT_RAM_WRITE_THROUGH_EN
    end else if (w_in_range) begin
      r_q <= data;
`else
    end else begin
      r_q <= r_q;
`endif
    end
  end

  assign q = r_q;

endmodule

// File: tb/tb_singleport_ram.sv
// tb_singleport_ram: directed bench for singleport_ram. Two instances share
// stimulus: a full 64-word RAM and a 48-word RAM that exercises the
// out-of-range behaviour. A reference model computes expected q for both,
// pushes it to a scoreboard queue when the step is driven, and pops it for
// comparison one edge later.
module tb_singleport_ram;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic [5:0] addr;
  logic       WE;
  logic [7:0] q64;
  logic [7:0] q48;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] q64;
    logic [7:0] q48;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m64 [64];
  logic [7:0] m48 [48];
  logic [7:0] mq64;
  logic [7:0] mq48;

  singleport_ram #(.addr_width(6), .data_width(8), .depth(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .data(data), .addr(addr), .WE(WE), .q(q64)
  );

  singleport_ram #(.addr_width(6), .data_width(8), .depth(48)) dut48 (
    .clk(clk), .rst_n(rst_n), .data(data), .addr(addr), .WE(WE), .q(q48)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m64[i] = 8'h00;
    for (int i = 0; i < 48; i++) m48[i] = 8'h00;
    mq64 = 8'h00;
    mq48 = 8'h00;
    sb.delete();
  endtask

  // One clock edge of stimulus: drive after a falling edge, model the
  // rising edge, compare #1 after it, return at the next falling edge.
  task automatic step(input string tag, input logic we_i, input logic [5:0] a,
                      input logic [7:0] d);
    exp_t e;
    WE   = we_i;
    addr = a;
    data = d;
    if (we_i) begin
      m64[a] = d;
`ifdef SINGLEPORT_RAM_WRITE_THROUGH_EN
      mq64 = d;
`endif
      if (a < 48) begin
        m48[a] = d;
`ifdef SINGLEPORT_RAM_WRITE_THROUGH_EN
        mq48 = d;
`endif
      end
    end else begin
      mq64 = m64[a];
      mq48 = (a < 48) ? m48[a] : 8'h00;
    end
    e.q64 = mq64;
    e.q48 = mq48;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 8'h01, 8'h00);
    end else begin
      e = sb.pop_front();
      check({tag, "_q64"}, q64, e.q64);
      check({tag, "_q48"}, q48, e.q48);
    end
    @(negedge clk);
  endtask

  // Assert reset between edges and check q clears without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_q64_now"}, q64, 8'h00);
    check({tag, "_q48_now"}, q48, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    WE    = 1'b0;
    addr  = '0;
    data  = '0;
    model_reset();
    #1;
    check("reset_q64", q64, 8'h00);
    check("reset_q48", q48, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset with prior content at addr 5.
    step("pre_wr5", 1'b1, 6'd5, 8'h5A);
    step("pre_rd5", 1'b0, 6'd5, 8'h00);
    check("pre_rd5_direct", q64, 8'h5A);
    async_reset("rst1");
    step("post_rd5", 1'b0, 6'd5, 8'h00);

    // Basic write then read-back.
    step("wr0", 1'b1, 6'd0, 8'h01);
    step("wr1", 1'b1, 6'd1, 8'h02);
    step("wr2", 1'b1, 6'd2, 8'h03);
    step("rd0", 1'b0, 6'd0, 8'h00);
    step("rd1", 1'b0, 6'd1, 8'h00);
    step("rd2", 1'b0, 6'd2, 8'h00);

    // Write-cycle output behaviour.
    step("wr7", 1'b1, 6'd7, 8'hAA);
`ifdef SINGLEPORT_RAM_WRITE_THROUGH_EN
    check("wr7_direct", q64, 8'hAA);
`else
    check("wr7_direct", q64, 8'h03);
`endif
    step("rd7", 1'b0, 6'd7, 8'h00);

    // Overwrite at the top address; low address must not disturb it.
    step("wr63a", 1'b1, 6'd63, 8'h55);
    step("wr63b", 1'b1, 6'd63, 8'hA5);
    step("rd63a", 1'b0, 6'd63, 8'h00);
    step("wr0ff", 1'b1, 6'd0, 8'hFF);
    step("rd63b", 1'b0, 6'd63, 8'h00);
    check("rd63b_direct", q64, 8'hA5);
    step("rd0ff", 1'b0, 6'd0, 8'h00);

    // Reset in the middle of a write burst.
    step("burst10", 1'b1, 6'd10, 8'h3C);
    step("burst11", 1'b1, 6'd11, 8'hC3);
    WE   = 1'b1;
    addr = 6'd12;
    data = 8'h99;
    async_reset("rst2");
    for (int i = 0; i < 3; i++) step("post_rd", 1'b0, 6'(i), 8'h00);
    step("post_rd10", 1'b0, 6'd10, 8'h00);
    step("post_rd12", 1'b0, 6'd12, 8'h00);

    // Out of range on the 48-word instance.
    step("wr47", 1'b1, 6'd47, 8'h11);
    step("wr50", 1'b1, 6'd50, 8'h77);
    step("rd50", 1'b0, 6'd50, 8'h00);
    check("rd50_q48_direct", q48, 8'h00);
    check("rd50_q64_direct", q64, 8'h77);
    step("rd47", 1'b0, 6'd47, 8'h00);
    for (int i = 0; i < 48; i++) step("scan", 1'b0, 6'(i), 8'h00);
    step("wr63c", 1'b1, 6'd63, 8'h42);
    step("rd63c", 1'b0, 6'd63, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/singleport_ram.md
Name: singleport_ram

Overview:
- Synchronous single-port RAM: one shared address bus for writes and reads, one write-enable, registered read data.
- Default geometry is 64 words x 8 bits.
- Serves as a generic scratchpad/storage primitive inside larger datapaths.
- One clock domain; asynchronous active-low reset clears the contents.

Parameters:
- addr_width, 6: address bus width in bits.
- data_width, 8: word width in bits.
- depth, 64: number of words implemented; must satisfy depth <= 2**addr_width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- data  input  data_width  write data.
- addr  input  addr_width  shared read/write address.
- WE  input  1  write enable, active-high; 1 = write cycle, 0 = read cycle.
- q  output  data_width  registered read data.

Behaviour:
- Reset (rst_n = 0, asynchronous, independent of clk):
  - q = 0 immediately.
  - All depth words of storage = 0.
  - Held for the whole time rst_n is low. Clocks and WE are ignored during reset.
  - Deassertion takes effect at the next rising edge.
- Write (rising edge, WE = 1, addr < depth): mem[addr] <= data.
- Read (rising edge, WE = 0, addr < depth): q <= mem[addr].
  - Read latency is 1 cycle: q is valid after the edge that sampled addr.
  - A word written on edge N can be read by a read sampled on edge N+1.
- q during a write cycle: holds its previous value (no-change). See Optional Feature for write-through.
- q between reads: stable. It changes only on a read edge or on reset.
- Out of range (addr >= depth, only possible when depth < 2**addr_width):
  - A write is ignored and storage is unchanged.
  - A read loads q with 0.
- Back-to-back operations: a write then a read of the same address on consecutive edges returns the new data.
- No handshake: every edge performs exactly one operation, selected by WE.
- No X propagation: storage is defined from reset, so every read returns a defined value.
- Reset mid-operation: a write in the same cycle that reset asserts is lost, and the word is 0 after reset.
- Widths: data and q are exactly data_width. addr is exactly addr_width; the upper bits of a wider driving bus are not used.

Optional Feature:
- Macro: SINGLEPORT_RAM_WRITE_THROUGH_EN.
- Defined: write-first mode. On a write edge (WE = 1, addr < depth), q <= data in the same cycle as the storage update, so written data appears on q one cycle later.
- Undefined (default): no-change mode. q holds its previous value on write cycles.
- Storage behaviour and read behaviour are identical in both modes.

Test Plan:
- Reset: rst_n = 0 with prior content at addr 5 -> q = 0 immediately. After release, a read of addr 5 -> q = 8'h00.
- Basic write/read:
  - Stimulus: WE = 1, write 8'h01@0, 8'h02@1, 8'h03@2 on consecutive edges. Then WE = 0, read addr 0, 1, 2 on consecutive edges.
  - Required: q = 8'h01, 8'h02, 8'h03, each one cycle after its address is sampled.
- Write-cycle output:
  - After a read giving q = 8'h03, write 8'hAA@7.
  - Default: q stays 8'h03.
  - With SINGLEPORT_RAM_WRITE_THROUGH_EN: q = 8'hAA one cycle later.
- Overwrite and boundary:
  - Write 8'h55@63, then 8'hA5@63; read 63 -> q = 8'hA5.
  - Write 8'hFF@0 must not disturb addr 63: read 63 -> still 8'hA5.
- Reset mid-operation:
  - Assert rst_n = 0 asynchronously between edges during a WE = 1 burst -> q = 0 immediately.
  - After release, reads of addresses 0-2 -> 8'h00.
- Out of range: with depth = 48, write 8'h77@50 then read 50 -> q = 8'h00. Addresses 0-47 are unchanged.
